// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared constants and types for the fetch redirect controller.
// Error codes, address-map defaults and the FSM state encoding.
package fetch_redirect_ctrl_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam logic [31:0] IM_LAST_DEF  = 32'h0000_4FFF;

  localparam logic [4:0] ERR_ADEL = 5'd4;
  localparam logic [4:0] ERR_NONE = 5'd31;

  localparam int unsigned IM_AW = 12;
  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_addr_check.sv
// Combinational fetch-address check: alignment and IM range, plus the IM word index.
module fetch_addr_check
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] IM_BASE = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST = IM_LAST_DEF
) (
  input  logic [31:0]      pc,
  output logic             fetch_err,
  output logic [4:0]       err_code,
  output logic [IM_AW-1:0] im_addr
);

  always_comb begin
    fetch_err = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_LAST);
    err_code  = fetch_err ? ERR_ADEL : ERR_NONE;
    im_addr   = IM_AW'((pc - IM_BASE) >> 2);
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC owner: arbitrates exception/eret/jump/branch/sequential and holds redirects across stalls.
// Optional macro REDIRECT_CNT_EN adds saturating redirect and exception counters.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
  parameter logic [31:0] IM_BASE  = IM_BASE_DEF,
  parameter logic [31:0] IM_LAST  = IM_LAST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc,
  output logic [31:0] pc_4,
  output logic [11:0] im_addr,
  output logic        fetch_err,
  output logic [4:0]  err_code,
  output logic        if_flush,
  output logic        pending
`ifdef REDIRECT_CNT_EN
  ,
  output logic [15:0] redir_cnt,
  output logic [15:0] exc_cnt
`endif
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] tgt_q, tgt_d;
  logic        if_flush_q, if_flush_d;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      tgt_q      <= '0;
      if_flush_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      tgt_q      <= tgt_d;
      if_flush_q <= if_flush_d;
    end
  end

  // Next-state: HOLD is entered only from RUN on a stalled jump/branch
  always_comb begin
    state_d = state_q;
    if (exc_req || eret_req) begin
      state_d = RUN;
    end else if (stall) begin
      if (state_q == RUN && (jump || branch)) state_d = HOLD;
    end else begin
      state_d = RUN;
    end
  end

  // Next PC, pending target and flush
  always_comb begin
    pc_d       = pc_4;
    tgt_d      = tgt_q;
    if_flush_d = 1'b0;
    if (exc_req) begin
      pc_d       = EXC_VEC;
      if_flush_d = 1'b1;
    end else if (eret_req) begin
      pc_d       = epc;
      if_flush_d = 1'b1;
    end else if (stall) begin
      pc_d = pc_q;
      if (state_q == RUN && (jump || branch)) tgt_d = jump ? jump_addr : branch_addr;
    end else if (state_q == HOLD) begin
      pc_d = tgt_q;
    end else if (jump) begin
      pc_d = jump_addr;
    end else if (branch) begin
      pc_d = branch_addr;
    end
  end

  always_comb begin
    pc       = pc_q;
    pc_4     = pc_q + 32'd4;
    if_flush = if_flush_q;
    pending  = (state_q == HOLD);
  end

  fetch_addr_check #(
    .IM_BASE (IM_BASE),
    .IM_LAST (IM_LAST)
  ) u_addr_check (
    .pc        (pc_q),
    .fetch_err (fetch_err),
    .err_code  (err_code),
    .im_addr   (im_addr)
  );

`ifdef REDIRECT_CNT_EN
  logic             redir_inc, exc_inc;
  logic [CNT_W-1:0] redir_cnt_q, redir_cnt_d;
  logic [CNT_W-1:0] exc_cnt_q, exc_cnt_d;

  // An applied redirect is a pending release or a direct jump/branch that wins arbitration
  always_comb begin
    exc_inc     = exc_req || eret_req;
    redir_inc   = !exc_inc && !stall && (state_q == HOLD || jump || branch);
    redir_cnt_d = redir_cnt_q;
    exc_cnt_d   = exc_cnt_q;
    if (redir_inc && redir_cnt_q != '1) redir_cnt_d = redir_cnt_q + CNT_W'(1);
    if (exc_inc && exc_cnt_q != '1)     exc_cnt_d   = exc_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      redir_cnt_q <= '0;
      exc_cnt_q   <= '0;
    end else begin
      redir_cnt_q <= redir_cnt_d;
      exc_cnt_q   <= exc_cnt_d;
    end
  end

  always_comb begin
    redir_cnt = redir_cnt_q;
    exc_cnt   = exc_cnt_q;
  end
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Testbench for fetch_redirect_ctrl: directed vector table plus randomized run against a queue-based model.
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset, stall, exc_req, eret_req, jump, branch;
  logic [31:0] epc, jump_addr, branch_addr;
  logic [31:0] pc, pc_4;
  logic [11:0] im_addr;
  logic        fetch_err, if_flush, pending;
  logic [4:0]  err_code;
`ifdef REDIRECT_CNT_EN
  logic [15:0] redir_cnt, exc_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_redirect_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .exc_req(exc_req), .eret_req(eret_req),
    .epc(epc), .jump(jump), .jump_addr(jump_addr), .branch(branch), .branch_addr(branch_addr),
    .pc(pc), .pc_4(pc_4), .im_addr(im_addr), .fetch_err(fetch_err), .err_code(err_code),
    .if_flush(if_flush), .pending(pending)
`ifdef REDIRECT_CNT_EN
    , .redir_cnt(redir_cnt), .exc_cnt(exc_cnt)
`endif
  );

  typedef struct packed {
    logic        rst_n;
    logic        stall;
    logic        exc;
    logic        eret;
    logic [31:0] epc;
    logic        j;
    logic [31:0] ja;
    logic        b;
    logic [31:0] ba;
    logic [31:0] exp_pc;
    logic        exp_pend;
    logic        exp_flush;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic bit addr_bad(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h4FFF);
  endfunction

  // Observable outputs implied by a given pc, derived by plain arithmetic
  task automatic chk_pc_outputs(input string tag, input logic [31:0] exp_pc);
    bit e;
    e = addr_bad(exp_pc);
    chk({tag, ".pc"}, pc, exp_pc);
    chk({tag, ".pc_4"}, pc_4, exp_pc + 32'd4);
    chk({tag, ".fetch_err"}, {31'd0, fetch_err}, {31'd0, e});
    chk({tag, ".err_code"}, {27'd0, err_code}, e ? 32'd4 : 32'd31);
    if (!e) chk({tag, ".im_addr"}, {20'd0, im_addr}, ((exp_pc - 32'h3000) / 4) % 4096);
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic x, input logic e,
                              input logic [31:0] ep, input logic j, input logic [31:0] ja,
                              input logic b, input logic [31:0] ba, input logic [31:0] xp,
                              input logic pd, input logic fl);
    vec_t v;
    v.rst_n = r; v.stall = s; v.exc = x; v.eret = e; v.epc = ep;
    v.j = j; v.ja = ja; v.b = b; v.ba = ba;
    v.exp_pc = xp; v.exp_pend = pd; v.exp_flush = fl;
    return v;
  endfunction

  task automatic drive(input logic r, input logic s, input logic x, input logic e,
                       input logic [31:0] ep, input logic j, input logic [31:0] ja,
                       input logic b, input logic [31:0] ba);
    reset = r; stall = s; exc_req = x; eret_req = e; epc = ep;
    jump = j; jump_addr = ja; branch = b; branch_addr = ba;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0, 1: a = 32'h3000 + 32'($urandom_range(0, 2047)) * 4;
      2:    a = 32'h3000 + 32'($urandom_range(0, 2047)) * 4 + 32'($urandom_range(1, 3));
      3:    a = $urandom;
      default: case ($urandom_range(0, 4))
        0: a = 32'h2FFC;
        1: a = 32'h3000;
        2: a = 32'h4FFC;
        3: a = 32'h5000;
        default: a = 32'hFFFF_FFFC;
      endcase
    endcase
    return a;
  endfunction

  // Reference model state: pending redirects kept as a queue (at most one entry)
  logic [31:0] m_pc;
  logic [31:0] m_q [$];
  logic        m_flush;
  int unsigned m_redir, m_exc;

  task automatic model_step();
    if (!reset) begin
      m_pc = 32'h3000; m_q.delete(); m_flush = 0; m_redir = 0; m_exc = 0;
    end else if (exc_req || eret_req) begin
      m_pc = exc_req ? 32'h4180 : epc;
      m_q.delete(); m_flush = 1;
      if (m_exc < 16'hFFFF) m_exc++;
    end else begin
      m_flush = 0;
      if (stall) begin
        if (m_q.size() == 0 && (jump || branch)) m_q.push_back(jump ? jump_addr : branch_addr);
      end else if (m_q.size() != 0) begin
        m_pc = m_q.pop_front();
        if (m_redir < 16'hFFFF) m_redir++;
      end else if (jump || branch) begin
        m_pc = jump ? jump_addr : branch_addr;
        if (m_redir < 16'hFFFF) m_redir++;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);

    //          rst s  x  e  epc       j  ja        b  ba        exp_pc    pd fl
    vecs[0]  = mk(0, 0, 0, 0, 0,        0, 0,        0, 0,        32'h3000, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0,        0, 0,        0, 0,        32'h3004, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0,        0, 0,        0, 0,        32'h3008, 0, 0);
    vecs[3]  = mk(1, 0, 0, 0, 0,        0, 0,        0, 0,        32'h300C, 0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 0,        1, 32'h3400, 0, 0,        32'h300C, 1, 0);
    vecs[5]  = mk(1, 1, 0, 0, 0,        0, 0,        0, 0,        32'h300C, 1, 0);
    vecs[6]  = mk(1, 1, 0, 0, 0,        1, 32'h3800, 0, 0,        32'h300C, 1, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0,        1, 32'h3900, 0, 0,        32'h3400, 0, 0);
    vecs[8]  = mk(1, 1, 0, 0, 0,        0, 0,        1, 32'h3400, 32'h3400, 1, 0);
    vecs[9]  = mk(1, 1, 1, 0, 0,        0, 0,        0, 0,        32'h4180, 0, 1);
    vecs[10] = mk(1, 0, 0, 0, 0,        0, 0,        0, 0,        32'h4184, 0, 0);
    vecs[11] = mk(1, 0, 0, 1, 32'h3010, 0, 0,        1, 32'h3100, 32'h3010, 0, 1);
    vecs[12] = mk(1, 0, 0, 0, 0,        1, 32'h3002, 0, 0,        32'h3002, 0, 0);
    vecs[13] = mk(1, 0, 0, 0, 0,        0, 0,        0, 0,        32'h3006, 0, 0);
    vecs[14] = mk(1, 0, 0, 0, 0,        1, 32'h5000, 0, 0,        32'h5000, 0, 0);
    vecs[15] = mk(1, 0, 0, 0, 0,        1, 32'h4FFC, 0, 0,        32'h4FFC, 0, 0);
    vecs[16] = mk(1, 0, 0, 0, 0,        0, 0,        0, 0,        32'h5000, 0, 0);
    vecs[17] = mk(1, 1, 0, 0, 0,        1, 32'h3200, 0, 0,        32'h5000, 1, 0);
    vecs[18] = mk(1, 0, 1, 1, 32'h3300, 0, 0,        0, 0,        32'h4180, 0, 1);
    vecs[19] = mk(1, 1, 0, 0, 0,        1, 32'h3500, 0, 0,        32'h4180, 1, 0);
    vecs[20] = mk(0, 0, 1, 0, 0,        0, 0,        0, 0,        32'h3000, 0, 0);
    vecs[21] = mk(1, 0, 0, 0, 0,        0, 0,        0, 0,        32'h3004, 0, 0);
    vecs[22] = mk(1, 0, 0, 0, 0,        1, 32'h2FFC, 0, 0,        32'h2FFC, 0, 0);
    vecs[23] = mk(1, 0, 0, 0, 0,        1, 32'h3100, 1, 32'h3FF0, 32'h3100, 0, 0);
    vecs[24] = mk(1, 0, 0, 0, 0,        0, 0,        1, 32'h3FF0, 32'h3FF0, 0, 0);

    #2;
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst_n, vecs[i].stall, vecs[i].exc, vecs[i].eret, vecs[i].epc,
            vecs[i].j, vecs[i].ja, vecs[i].b, vecs[i].ba);
      @(posedge clk); #1;
      chk_pc_outputs($sformatf("vec%0d", i), vecs[i].exp_pc);
      chk($sformatf("vec%0d.pending", i), {31'd0, pending}, {31'd0, vecs[i].exp_pend});
      chk($sformatf("vec%0d.if_flush", i), {31'd0, if_flush}, {31'd0, vecs[i].exp_flush});
    end

    // Randomized run; first cycle resets to sync the model
    for (int n = 0; n < 3000; n++) begin
      drive((n != 0) && ($urandom_range(0, 63) != 0),
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 19) == 0,
            rand_addr(),
            $urandom_range(0, 4) == 0, rand_addr(),
            $urandom_range(0, 4) == 0, rand_addr());
      model_step();
      @(posedge clk); #1;
      chk_pc_outputs($sformatf("rnd%0d", n), m_pc);
      chk($sformatf("rnd%0d.pending", n), {31'd0, pending}, {31'd0, (m_q.size() != 0)});
      chk($sformatf("rnd%0d.if_flush", n), {31'd0, if_flush}, {31'd0, m_flush});
`ifdef REDIRECT_CNT_EN
      chk($sformatf("rnd%0d.redir_cnt", n), {16'd0, redir_cnt}, m_redir);
      chk($sformatf("rnd%0d.exc_cnt", n), {16'd0, exc_cnt}, m_exc);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
